sigmoid_alu_mac_driver: RTL
===========================

Name: sigmoid_alu_mac_driver

Overview:
Producer side of the sigmoid ALU accumulator interface. Accepts a stream of signed operand pairs over a valid/ready handshake and multiplies each pair into a 10-bit signed term. Drives the accumulator's clear, accumulate and newval inputs, one term per cycle. Pulses done in the cycle the accumulator output holds the final dot-product sum, where the sigmoid lookup stage reads it.

Parameters:
CNT_W, 11, width of the term count; supports up to 2^CNT_W-1 terms per dot product
OPERAND_W, 5, signed operand width; the product width is 2*OPERAND_W (10)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
start  input  1  begin a new dot product; sampled only in IDLE
abort  input  1  cancel the current operation; return to IDLE
num_terms  input  CNT_W  number of products to accumulate; latched on start
data_valid  input  1  operand pair on operand_a/operand_b is valid
operand_a  input  OPERAND_W  signed input activation
operand_b  input  OPERAND_W  signed weight
data_ready  output  1  driver accepts an operand pair this cycle
clear  output  1  to accumulator clear
accumulate  output  1  to accumulator accumulate
newval  output  10  to accumulator newval, signed product
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; accumulator out is final in this cycle

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (n_rst).
- Reset values: state=IDLE, term count=0, accumulate=0, newval=0, done=0, clear=0, data_ready=0, busy=0.
- States are IDLE, CLEAR, RUN, FLUSH and DONE. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE: if start=1 and abort=0, latch num_terms, zero the term count, and go to CLEAR.
- CLEAR: lasts exactly 1 cycle with clear=1. Next state is RUN if the latched num_terms is non-zero; if it is zero, next state is DONE, so out=0 at done.
- RUN: data_ready=1. A handshake occurs when data_valid and data_ready are both 1.
- On each handshake:
  - newval <= sign-extended operand_a * operand_b, 10-bit signed.
  - accumulate <= 1 for the next cycle only; with no handshake, accumulate <= 0 and newval holds.
  - The term count increments.
- On the handshake where count == num_terms-1, go to FLUSH. data_ready drops in the next cycle, so there is no over-acceptance.
- FLUSH: 1 cycle. The last accumulate=1 is presented in this cycle. Go to DONE.
- DONE: 1 cycle with done=1. The accumulator out already reflects every term. Go to IDLE.
- Latency: the accumulate for a term is asserted 1 cycle after its handshake. done is asserted 2 cycles after the final handshake.
- Throughput: 1 term per cycle while data_valid is held high. Gaps in data_valid insert accumulate=0 cycles and never corrupt the sum.
- clear and accumulate are never high in the same cycle.
- start is ignored while busy=1. num_terms changes after start have no effect.
- abort, in any state: next state is IDLE, accumulate forced to 0 next cycle (a pending term is dropped), no done pulse. If start and abort are high in IDLE in the same cycle, abort wins.
- Arithmetic: signed 5x5 multiply with range -240..256, which fits 10 bits signed. Overflow of the 16-bit accumulator wraps and is not detected by this block.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous).

Decomposition:
- Package sigmoid_alu_pkg holds:
  - The state enum (IDLE, CLEAR, RUN, FLUSH, DONE).
  - Constants OPERAND_W=5, PRODUCT_W=10, ACC_W=16.
- One sub-module, sigmoid_alu_term_counter: CNT_W-bit counter with synchronous clear, enable, and a last flag that is 1 when count == limit-1.
- The multiply stays inline in the top level.

Test Plan:
1. num_terms=3 with pairs (2,3), (-4,5), (7,-1) streamed back-to-back. Required: clear for 1 cycle, then accumulate on 3 consecutive cycles with newval 6, -20, -7. done is 2 cycles after the third handshake and the accumulator out reads -21 (0xFFEB).
2. num_terms=4 with data_valid toggling 1,0,1,0,... Required: exactly 4 accumulate pulses with accumulate=0 in the gap cycles, and the sum is correct.
3. num_terms=0. Required: CLEAR then DONE, data_ready never asserted, out=0 at done.
4. Extremes: (-16,-16) and (15,-16). Required: newval 256 (0x100) and -240 (0x310).
5. abort asserted mid-RUN after 2 of 5 handshakes. Required: accumulate=0 the next cycle, no done pulse, IDLE. A following start with num_terms=1 and pair (1,1) gives clear, then sum 1.
6. start pulsed while busy, and n_rst asserted during RUN. Required: the second start is ignored. On reset, all outputs go to 0 asynchronously, state is IDLE, and the driver recovers on the next start.

Source files
------------

// File: rtl/sigmoid_alu_pkg.sv
// Shared types and constants for the sigmoid ALU accumulator driver.
package sigmoid_alu_pkg;

    localparam int OPERAND_W = 5;
    localparam int PRODUCT_W = 2 * OPERAND_W;
    localparam int ACC_W     = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sigmoid_alu_term_counter.sv
// Term counter for the MAC driver; flags the final term of a dot product.
module sigmoid_alu_term_counter
    import sigmoid_alu_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_last = (r_count == i_limit - CNT_W'(1));

endmodule

// File: rtl/sigmoid_alu_mac_driver.sv
// Producer side of the sigmoid ALU accumulator: streams signed products
// into the accumulator and flags the cycle its output holds the final sum.
module sigmoid_alu_mac_driver #(
    parameter int CNT_W     = 11,
    parameter int OPERAND_W = 5
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CNT_W-1:0]              num_terms,
    input  logic                          data_valid,
    input  logic signed [OPERAND_W-1:0]   operand_a,
    input  logic signed [OPERAND_W-1:0]   operand_b,
    output logic                          data_ready,
    output logic                          clear,
    output logic                          accumulate,
    output logic signed [2*OPERAND_W-1:0] newval,
    output logic                          busy,
    output logic                          done
);

    import sigmoid_alu_pkg::*;

    localparam int P_W = 2 * OPERAND_W;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_num_terms;
    logic                  r_accumulate;
    logic signed [P_W-1:0] r_newval;

    logic                  w_handshake;
    logic                  w_take;
    logic                  w_cnt_clr;
    logic                  w_last;
    logic signed [P_W-1:0] w_product;

    assign w_handshake = (r_state == RUN) && data_valid;
    assign w_take      = w_handshake && !abort;
    assign w_cnt_clr   = (r_state == IDLE) && start && !abort;
    assign w_product   = P_W'(operand_a) * P_W'(operand_b);

    sigmoid_alu_term_counter #(
        .CNT_W(CNT_W)
    ) u_term_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_clear (w_cnt_clr),
        .i_enable(w_take),
        .i_limit (r_num_terms),
        .o_last  (w_last)
    );

    // abort overrides every state, including a start seen in IDLE
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (start) w_next = CLEAR;
                CLEAR:   w_next = (r_num_terms != '0) ? RUN : DONE;
                RUN:     if (w_handshake && w_last) w_next = FLUSH;
                FLUSH:   w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_num_terms  <= '0;
            r_accumulate <= 1'b0;
            r_newval     <= '0;
        end else begin
            r_state      <= w_next;
            r_accumulate <= w_take;
            if (w_cnt_clr) r_num_terms <= num_terms;
            if (w_take)    r_newval    <= w_product;
        end
    end

    assign data_ready = (r_state == RUN);
    assign clear      = (r_state == CLEAR);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign accumulate = r_accumulate;
    assign newval     = r_newval;

endmodule
